fifo_stream_reader: RTL and testbench

Read-side consumer for the synchronous FIFO: issues `rd_en` pops whenever the FIFO holds data and local space exists, captures the registered `data_out` one cycle later, and presents words on a valid/ready stream toward downstream logic. It sits between the FIFO's read port and any stream consumer. It also tracks words delivered and latches FIFO underflow as a sticky error.

---
 rtl/fifo_reader_pkg.sv | 26 ++
 rtl/fifo_rd_skid.sv | 81 ++++++++
 rtl/fifo_stream_reader.sv | 114 +++++++++++
 tb/tb_fifo_stream_reader.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_reader_pkg.sv
// Shared types and sizing for the FIFO read-side stream adapter.
// The issue check projects next-cycle buffer usage before a new pop is requested.
package fifo_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

    localparam int unsigned BUF_DEPTH   = 2;
    localparam int unsigned OCC_WIDTH   = 2;
    localparam int unsigned PROJ_WIDTH  = 3;

    // A new pop is safe when current words, the word landing now, and the new one fit.
    function automatic logic issue_fits(
        input logic [OCC_WIDTH-1:0] occ,
        input logic                 inflight,
        input logic                 pop
    );
        logic [PROJ_WIDTH-1:0] proj;
        proj = PROJ_WIDTH'(occ) + PROJ_WIDTH'(inflight) + PROJ_WIDTH'(1) - PROJ_WIDTH'(pop);
        return proj <= PROJ_WIDTH'(BUF_DEPTH);
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry ordered buffer: head drives the stream, tail catches the word behind it.
// Head data only changes on a pop or when filling an empty head, so it holds under backpressure.
module fifo_rd_skid
    import fifo_reader_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 pop,
    output logic [WIDTH-1:0]     head_data,
    output logic                 head_valid,
    output logic [OCC_WIDTH-1:0] occ_c
);

    logic [WIDTH-1:0] tail_data;
    logic             tail_valid;

    logic [WIDTH-1:0] head_data_next;
    logic             head_valid_next;
    logic [WIDTH-1:0] tail_data_next;
    logic             tail_valid_next;
    logic             pop_ok;

    assign pop_ok = pop && head_valid;
    assign occ_c  = OCC_WIDTH'(head_valid) + OCC_WIDTH'(tail_valid);

    always_comb begin
        head_data_next  = head_data;
        head_valid_next = head_valid;
        tail_data_next  = tail_data;
        tail_valid_next = tail_valid;

        case ({wr, pop_ok})
            2'b10: begin
                if (!head_valid) begin
                    head_data_next  = wr_data;
                    head_valid_next = 1'b1;
                end else if (!tail_valid) begin
                    tail_data_next  = wr_data;
                    tail_valid_next = 1'b1;
                end
            end
            2'b01: begin
                if (tail_valid) begin
                    head_data_next = tail_data;
                end
                head_valid_next = tail_valid;
                tail_valid_next = 1'b0;
            end
            2'b11: begin
                // Tail advances to head and the new word takes the tail slot.
                if (tail_valid) begin
                    head_data_next = tail_data;
                    tail_data_next = wr_data;
                end else begin
                    head_data_next = wr_data;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_data  <= '0;
            head_valid <= 1'b0;
            tail_data  <= '0;
            tail_valid <= 1'b0;
        end else begin
            head_data  <= head_data_next;
            head_valid <= head_valid_next;
            tail_data  <= tail_data_next;
            tail_valid <= tail_valid_next;
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side consumer of the synchronous FIFO: pops when space allows, captures the
// registered read data one cycle later and presents it on a valid/ready stream.
module fifo_stream_reader
    import fifo_reader_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  words_read,
    output logic                  err_underflow,
    output logic                  busy
);

    if (FIFO_WIDTH == 0 || FIFO_DEPTH == 0 || CNT_WIDTH == 0) begin : g_param_check
        $error("fifo_stream_reader: FIFO_WIDTH, FIFO_DEPTH and CNT_WIDTH must be non-zero");
    end

    rd_state_t              state;
    rd_state_t              state_next;
    logic                   inflight;
    logic                   pop;
    logic [OCC_WIDTH-1:0]   occ;
    logic                   drained;

    assign pop     = m_valid && m_ready;
    assign drained = (occ == '0) && !inflight;

    // Pop only when running, data exists, and the projected buffer usage fits.
    assign fifo_rd_en = (state == RUN) && !fifo_empty && issue_fits(occ, inflight, pop);

    fifo_rd_skid #(
        .WIDTH (FIFO_WIDTH)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr         (inflight),
        .wr_data    (fifo_data_out),
        .pop        (pop),
        .head_data  (m_data),
        .head_valid (m_valid),
        .occ_c      (occ)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (enable) begin
                    state_next = RUN;
                end else if (drained) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            inflight <= 1'b0;
        end else begin
            state    <= state_next;
            busy     <= (state_next != IDLE);
            inflight <= fifo_rd_en;
        end
    end

    // Delivered-word counter saturates; underflow flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            words_read    <= '0;
            err_underflow <= 1'b0;
        end else begin
            if (pop && (words_read != '1)) begin
                words_read <= words_read + CNT_WIDTH'(1);
            end
            if (fifo_underflow) begin
                err_underflow <= 1'b1;
            end
        end
    end

    a_no_pop_when_empty : assert property (@(posedge clk) disable iff (!rst_n)
        fifo_rd_en |-> !fifo_empty);

    a_no_buffer_overrun : assert property (@(posedge clk) disable iff (!rst_n)
        inflight && !pop |-> (occ < OCC_WIDTH'(BUF_DEPTH)));

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader with a behavioural FIFO read port.
module tb_fifo_stream_reader;
    import fifo_reader_pkg::*;

    localparam int unsigned W = 16;
    localparam int unsigned C = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          fifo_empty;
    logic          fifo_underflow = 1'b0;
    logic [W-1:0]  fifo_data_out = '0;
    logic          fifo_rd_en;
    logic [W-1:0]  m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [C-1:0]  words_read;
    logic          err_underflow;
    logic          busy;

    fifo_stream_reader #(
        .FIFO_WIDTH (W),
        .FIFO_DEPTH (8),
        .CNT_WIDTH  (C)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .fifo_empty     (fifo_empty),
        .fifo_underflow (fifo_underflow),
        .fifo_data_out  (fifo_data_out),
        .fifo_rd_en     (fifo_rd_en),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .words_read     (words_read),
        .err_underflow  (err_underflow),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int phase = 0;

    // Behavioural FIFO: registered read data, empty derived from push/pop counts.
    logic [W-1:0] mem [64];
    int pushed_cnt = 0;
    int popped_cnt = 0;
    assign fifo_empty = (pushed_cnt == popped_cnt);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en && (pushed_cnt != popped_cnt)) begin
            fifo_data_out <= mem[6'(popped_cnt)];
            popped_cnt    <= popped_cnt + 1;
        end
    end

    logic [W-1:0] exp_q [$];

    int first_rd  [10] = '{default: -1};
    int first_v   [10] = '{default: -1};
    int last_v    [10] = '{default: -1};
    int vcyc      [10] = '{default: 0};
    int rd_pulses [10] = '{default: 0};
    int acc       [10] = '{default: 0};

    function automatic void chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor: scoreboard compare on accepted beats, hold-stability and pop legality.
    logic         hold_prev = 1'b0;
    logic [W-1:0] hold_data = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            if (fifo_rd_en) begin
                chk_eq("rd_en_while_empty", 32'(fifo_empty), 32'd0);
                rd_pulses[phase]++;
                if (first_rd[phase] < 0) first_rd[phase] = cyc;
            end
            if (hold_prev) begin
                chk_eq("hold_valid", 32'(m_valid), 32'd1);
                chk_eq("hold_data", 32'(m_data), 32'(hold_data));
            end
            if (m_valid) begin
                vcyc[phase]++;
                if (first_v[phase] < 0) first_v[phase] = cyc;
                last_v[phase] = cyc;
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got 0x%0h expected none", m_data);
                end else begin
                    chk_eq("stream_data", 32'(m_data), 32'(exp_q.pop_front()));
                end
                acc[phase]++;
            end
            hold_prev = m_valid && !m_ready;
            hold_data = m_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [W-1:0] w);
        mem[6'(pushed_cnt)] = w;
        pushed_cnt = pushed_cnt + 1;
        exp_q.push_back(w);
    endtask

    task automatic wait_drained(input string name, input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        chk_eq({name, "_drain_left"}, 32'(exp_q.size()), 32'd0);
        repeat (3) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    logic [7:0] ready_pat;

    initial begin
        // Reset values
        repeat (3) tick();
        chk_eq("rst_m_valid", 32'(m_valid), 32'd0);
        chk_eq("rst_m_data", 32'(m_data), 32'd0);
        chk_eq("rst_words_read", 32'(words_read), 32'd0);
        chk_eq("rst_err", 32'(err_underflow), 32'd0);
        chk_eq("rst_busy", 32'(busy), 32'd0);
        chk_eq("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        rst_n = 1'b1;
        tick();

        // Full-rate stream of 8 words
        phase = 1;
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push_word(W'(i));
        enable = 1'b1;
        wait_drained("p1", 60);
        chk_eq("p1_latency", 32'(first_v[1] - first_rd[1]), 32'd2);
        chk_eq("p1_valid_cycles", 32'(vcyc[1]), 32'd8);
        chk_eq("p1_valid_span", 32'(last_v[1] - first_v[1]), 32'd7);
        chk_eq("p1_rd_pulses", 32'(rd_pulses[1]), 32'd8);
        chk_eq("p1_words_read", 32'(words_read), 32'd8);

        // Backpressure with full FIFO
        phase = 2;
        m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push_word(W'(i));
        repeat (10) tick();
        chk_eq("p2_rd_pulses", 32'(rd_pulses[2]), 32'd2);
        chk_eq("p2_occ", 32'(dut.occ), 32'd2);
        chk_eq("p2_m_valid", 32'(m_valid), 32'd1);
        chk_eq("p2_m_data", 32'(m_data), 32'h0001);
        phase = 3;
        m_ready = 1'b1;
        wait_drained("p3", 60);
        chk_eq("p3_rd_pulses", 32'(rd_pulses[3]), 32'd6);
        chk_eq("p3_accepted", 32'(acc[2] + acc[3]), 32'd8);
        chk_eq("p3_words_read", 32'(words_read), 32'd16);

        // Single-word FIFO
        phase = 4;
        push_word(16'h00A5);
        repeat (8) tick();
        chk_eq("p4_rd_pulses", 32'(rd_pulses[4]), 32'd1);
        chk_eq("p4_accepted", 32'(acc[4]), 32'd1);
        chk_eq("p4_err", 32'(err_underflow), 32'd0);
        chk_eq("p4_words_read", 32'(words_read), 32'd17);

        // Drop enable while pops are in flight: three words leave, two stay in the FIFO
        phase = 5;
        for (int i = 1; i <= 5; i++) push_word(16'h0500 + W'(i));
        tick();
        tick();
        enable = 1'b0;
        repeat (10) tick();
        chk_eq("p5_rd_pulses", 32'(rd_pulses[5]), 32'd3);
        chk_eq("p5_accepted", 32'(acc[5]), 32'd3);
        chk_eq("p5_busy", 32'(busy), 32'd0);
        chk_eq("p5_state", 32'(dut.state), 32'(IDLE));
        chk_eq("p5_words_read", 32'(words_read), 32'd20);

        // Sticky underflow
        phase = 6;
        fifo_underflow = 1'b1;
        tick();
        fifo_underflow = 1'b0;
        tick();
        chk_eq("p6_err_set", 32'(err_underflow), 32'd1);
        repeat (5) tick();
        chk_eq("p6_err_sticky", 32'(err_underflow), 32'd1);
        chk_eq("p6_no_pops_idle", 32'(rd_pulses[6]), 32'd0);

        // Reset mid-stream with two buffered words
        phase = 7;
        m_ready = 1'b0;
        enable = 1'b1;
        repeat (8) tick();
        chk_eq("p7_rd_pulses", 32'(rd_pulses[7]), 32'd2);
        chk_eq("p7_occ", 32'(dut.occ), 32'd2);
        chk_eq("p7_m_data", 32'(m_data), 32'h0504);
        rst_n = 1'b0;
        enable = 1'b0;
        tick();
        chk_eq("p7_rst_m_valid", 32'(m_valid), 32'd0);
        chk_eq("p7_rst_m_data", 32'(m_data), 32'd0);
        chk_eq("p7_rst_words_read", 32'(words_read), 32'd0);
        chk_eq("p7_rst_err", 32'(err_underflow), 32'd0);
        chk_eq("p7_rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        chk_eq("p7_queue_empty", 32'(exp_q.size()), 32'd0);
        tick();

        // Post-reset stream
        phase = 8;
        m_ready = 1'b1;
        enable = 1'b1;
        for (int i = 1; i <= 3; i++) push_word(16'h0800 + W'(i));
        wait_drained("p8", 40);
        chk_eq("p8_latency", 32'(first_v[8] - first_rd[8]), 32'd2);
        chk_eq("p8_words_read", 32'(words_read), 32'd3);

        // Irregular ready pattern keeps order and count
        phase = 9;
        ready_pat = 8'b0110_1001;
        for (int i = 1; i <= 6; i++) push_word(16'h0900 + W'(i));
        for (int i = 0; i < 24; i++) begin
            m_ready = ready_pat[i % 8];
            tick();
        end
        m_ready = 1'b1;
        wait_drained("p9", 40);
        chk_eq("p9_accepted", 32'(acc[9]), 32'd6);
        chk_eq("p9_words_read", 32'(words_read), 32'd9);
        enable = 1'b0;
        repeat (6) tick();
        chk_eq("p9_idle_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
